bp_me_lce_msg_arbiter: RTL
==========================

// Module: bp_me_lce_msg_arbiter
// PURPOSE
//  Round-robin arbiter sharing one LCE->CCE message link (request or response network) among
//  num_src_p LCE sources. Multi-beat messages are locked to one source until the last beat.
//  Zero-latency pass-through; stall watchdog and completed-message counter feed the nonsynth tracers.
// PARAMETERS
//  num_src_p       4    number of LCE sources sharing the link (>=2)
//  header_width_p  64   bedrock LCE header width, carried unmodified
//  data_width_p    64   data beat width
//  stall_limit_p   1024 stalled cycles before stall_err_o sets
//  cnt_width_p     32   width of msg_cnt_o
// PORTS
//  clk_i           in   1                        clock
//  reset_i         in   1                        reset
//  src_v_i         in   num_src_p                per-source beat valid
//  src_header_i    in   num_src_p*header_width_p per-source header (slice i = source i)
//  src_data_i      in   num_src_p*data_width_p   per-source data beat
//  src_last_i      in   num_src_p                beat is last of message
//  src_ready_and_o out  num_src_p                per-source ready
//  v_o             out  1                        link beat valid
//  header_o        out  header_width_p           selected header
//  data_o          out  data_width_p             selected data
//  last_o          out  1                        selected last flag
//  ready_and_i     in   1                        link ready
//  grant_id_o      out  clog2(num_src_p)         currently selected source
//  stall_err_o     out  1                        sticky watchdog error
//  msg_cnt_o       out  cnt_width_p              messages completed (last beats), wraps
// BEHAVIOUR
//  - Reset: reset_i, asynchronous, active-low; clock clk_i. Reset: state IDLE, rr ptr=0, lock_id=0,
//    stall_cnt=0, stall_err_o=0, msg_cnt_o=0; all src_ready_and_o=0, v_o=0.
//  - Handshake: beat transfers when v_o & ready_and_i. Sources hold valid/payload until ready.
//  - States: IDLE, LOCKED.
//  - IDLE: sel = first i with src_v_i[i], scanning ptr, ptr+1, ... mod num_src_p. No valid -> v_o=0,
//    grant_id_o=ptr. Outputs = slice sel combinationally; src_ready_and_o[sel]=ready_and_i, others 0.
//      transfer & last  -> stay IDLE, ptr=sel+1 mod num_src_p, msg_cnt_o+1
//      transfer & ~last -> LOCKED, lock_id=sel
//      v_o & ~ready     -> LOCKED, lock_id=sel (selection frozen; no switch while offered)
//  - LOCKED: sel=lock_id regardless of others; v_o=src_v_i[lock_id]; others' ready=0.
//      transfer & last  -> IDLE, ptr=lock_id+1 mod num_src_p, msg_cnt_o+1
//      otherwise stay LOCKED (bubbles from the locked source allowed).
//  - grant_id_o = sel every cycle. Output path purely combinational: 0-cycle latency.
//  - Watchdog: stall_cnt+1 each cycle with (v_o & ~ready_and_i) or (LOCKED & ~src_v_i[lock_id]);
//    cleared on any transfer; saturates at stall_limit_p; stall_err_o set when reached, sticky until reset.
//  - msg_cnt_o wraps 2^cnt_width_p-1 -> 0. ptr wraps num_src_p-1 -> 0 (non-power-of-2 supported).
//  - Single-beat message (last on first beat) never enters LOCKED if accepted same cycle.
//  - Reset asserted mid-message: drop lock, return to IDLE/ptr 0; partial message not counted.
// TESTING
//  1 Src0,src2 valid single-beat, ready=1, ptr=0 -> cycle0 grant 0, cycle1 grant 2, ptr=3, msg_cnt=2.
//  2 Src1 3-beat msg, src0 valid from beat2 -> all 3 beats from src1 contiguous, then src0; msg_cnt=2.
//  3 Src3 valid, ready=0 for 5 cycles, src0 asserts at cycle2 -> grant stays 3, src0 ready=0 throughout.
//  4 All 4 sources continuously valid single-beat, ready=1 -> grants 0,1,2,3,0,... each 25%.
//  5 stall_limit_p=8, src2 valid, ready=0 for 8 cycles -> stall_err_o=1 at cycle 8, stays 1 after ready.
//  6 Reset mid 4-beat msg after beat2 -> all outputs 0, IDLE, ptr=0, msg_cnt=0, next grant from src0 scan.

Source files
------------

// File: rtl/bp_me_lce_msg_arbiter_if.sv
// Bundle of the source-side and link-side handshake signals of the LCE message arbiter.
// Signal suffixes are as seen from the arbiter.
//   src_v_i / src_header_i / src_data_i / src_last_i : per-source beat (slice i = source i)
//   src_ready_and_o                                  : per-source ready
//   v_o / header_o / data_o / last_o                 : selected beat on the shared link
//   ready_and_i                                      : link ready
// Modports: slave = arbiter side, master = sources + link sink (environment side).
interface bp_me_lce_msg_arbiter_if
  #(parameter int unsigned num_src_p      = 4
   ,parameter int unsigned header_width_p = 64
   ,parameter int unsigned data_width_p   = 64
   );

   logic [num_src_p-1:0]                src_v_i;
   logic [num_src_p*header_width_p-1:0] src_header_i;
   logic [num_src_p*data_width_p-1:0]   src_data_i;
   logic [num_src_p-1:0]                src_last_i;
   logic [num_src_p-1:0]                src_ready_and_o;

   logic                                v_o;
   logic [header_width_p-1:0]           header_o;
   logic [data_width_p-1:0]             data_o;
   logic                                last_o;
   logic                                ready_and_i;

   modport slave
     (input  src_v_i, src_header_i, src_data_i, src_last_i, ready_and_i
     ,output src_ready_and_o, v_o, header_o, data_o, last_o
     );

   modport master
     (output src_v_i, src_header_i, src_data_i, src_last_i, ready_and_i
     ,input  src_ready_and_o, v_o, header_o, data_o, last_o
     );

endinterface

// File: rtl/bp_me_lce_msg_arbiter.sv
// Round-robin arbiter sharing one LCE->CCE message link among num_src_p sources.
// Multi-beat messages (and any beat offered but not yet accepted) lock the link to one
// source until its last beat transfers. The data path is purely combinational.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-low reset
//   link_if (slave) : per-source beats in / ready out, shared link beat out / ready in
//   grant_id_o      : currently selected source
//   stall_err_o     : sticky watchdog error (stall_limit_p stalled cycles without transfer)
//   msg_cnt_o       : count of completed messages (last beats transferred), wraps
module bp_me_lce_msg_arbiter
  #(parameter int unsigned num_src_p      = 4
   ,parameter int unsigned header_width_p = 64
   ,parameter int unsigned data_width_p   = 64
   ,parameter int unsigned stall_limit_p  = 1024
   ,parameter int unsigned cnt_width_p    = 32
   ,localparam int unsigned id_width_lp   = (num_src_p > 1) ? $clog2(num_src_p) : 1
   )
  (input  logic                   clk_i
  ,input  logic                   reset_i
  ,bp_me_lce_msg_arbiter_if.slave link_if
  ,output logic [id_width_lp-1:0] grant_id_o
  ,output logic                   stall_err_o
  ,output logic [cnt_width_p-1:0] msg_cnt_o
  );

   localparam int unsigned stall_width_lp = $clog2(stall_limit_p + 1);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]                state_q,     state_d;
   logic [id_width_lp-1:0]    ptr_q,       ptr_d;
   logic [id_width_lp-1:0]    lock_id_q,   lock_id_d;
   logic [stall_width_lp-1:0] stall_cnt_q, stall_cnt_d;
   logic                      stall_err_q, stall_err_d;
   logic [cnt_width_p-1:0]    msg_cnt_q,   msg_cnt_d;

   logic [header_width_p-1:0] hdr_arr  [num_src_p];
   logic [data_width_p-1:0]   data_arr [num_src_p];

   logic [id_width_lp-1:0]    scan_sel;
   logic                      scan_found;
   logic [id_width_lp-1:0]    sel;
   logic                      sel_v;
   logic                      sel_last;
   logic                      xfer;
   logic                      stalled;

   // Wrapping increment for source ids (non-power-of-2 counts supported).
   function automatic logic [id_width_lp-1:0] next_id(input logic [id_width_lp-1:0] id);
      if (id == id_width_lp'(num_src_p - 1))
         return '0;
      else
         return id + id_width_lp'(1);
   endfunction

   // Unpack flat per-source payload buses.
   always_comb begin
      for (int i = 0; i < int'(num_src_p); i++) begin
         hdr_arr[i]  = link_if.src_header_i[i*header_width_p +: header_width_p];
         data_arr[i] = link_if.src_data_i[i*data_width_p +: data_width_p];
      end
   end

   // First valid source scanning ptr, ptr+1, ... modulo num_src_p.
   always_comb begin
      int unsigned idx;
      scan_found = 1'b0;
      scan_sel   = ptr_q;
      idx        = 0;
      for (int unsigned off = 0; off < num_src_p; off++) begin
         idx = 32'(ptr_q) + off;
         if (idx >= num_src_p)
            idx = idx - num_src_p;
         if (!scan_found && link_if.src_v_i[id_width_lp'(idx)]) begin
            scan_found = 1'b1;
            scan_sel   = id_width_lp'(idx);
         end
      end
   end

   // Selection: frozen on lock_id while locked, otherwise the round-robin winner.
   always_comb begin
      if (state_q == ST_LOCKED) begin
         sel   = lock_id_q;
         sel_v = link_if.src_v_i[lock_id_q];
      end else begin
         sel   = scan_sel;
         sel_v = scan_found;
      end
      sel_last = link_if.src_last_i[sel];
      xfer     = sel_v & link_if.ready_and_i;
      stalled  = (sel_v & ~link_if.ready_and_i)
               | ((state_q == ST_LOCKED) & ~link_if.src_v_i[lock_id_q]);
   end

   // Combinational link outputs; forced quiet while reset is asserted.
   always_comb begin
      link_if.src_ready_and_o = '0;
      link_if.v_o             = 1'b0;
      link_if.header_o        = '0;
      link_if.data_o          = '0;
      link_if.last_o          = 1'b0;
      grant_id_o              = '0;
      if (reset_i) begin
         link_if.src_ready_and_o[sel] = link_if.ready_and_i;
         link_if.v_o                  = sel_v;
         link_if.header_o             = hdr_arr[sel];
         link_if.data_o               = data_arr[sel];
         link_if.last_o               = sel_last;
         grant_id_o                   = sel;
      end
   end

   assign stall_err_o = stall_err_q;
   assign msg_cnt_o   = msg_cnt_q;

   // Next-state: lock on any offered-but-incomplete beat, release on last transfer.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_id_d = lock_id_q;
      msg_cnt_d = msg_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_v) begin
               if (xfer && sel_last) begin
                  ptr_d     = next_id(sel);
                  msg_cnt_d = msg_cnt_q + cnt_width_p'(1);
               end else begin
                  state_d   = ST_LOCKED;
                  lock_id_d = sel;
               end
            end
         end
         ST_LOCKED: begin
            if (xfer && sel_last) begin
               state_d   = ST_IDLE;
               ptr_d     = next_id(lock_id_q);
               msg_cnt_d = msg_cnt_q + cnt_width_p'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Watchdog: saturating count of stalled cycles, cleared by any transfer.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (xfer)
         stall_cnt_d = '0;
      else if (stalled && (stall_cnt_q < stall_width_lp'(stall_limit_p)))
         stall_cnt_d = stall_cnt_q + stall_width_lp'(1);
      stall_err_d = stall_err_q | (stall_cnt_d >= stall_width_lp'(stall_limit_p));
   end

   // State registers.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         lock_id_q   <= '0;
         stall_cnt_q <= '0;
         stall_err_q <= 1'b0;
         msg_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_id_q   <= lock_id_d;
         stall_cnt_q <= stall_cnt_d;
         stall_err_q <= stall_err_d;
         msg_cnt_q   <= msg_cnt_d;
      end
   end

endmodule
